// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer, its control unit and the bench.
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_WRITE = 3'd3,
    S_ZERO  = 3'd4
  } seqState_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEFAULT_MULT_CYCLES = 32;
  localparam int DEFAULT_DIV_CYCLES  = 32;

  // Width of the latency counter: it only ever holds (cycles - 1), so
  // $clog2 of the larger latency is enough. Never narrower than one bit.
  function automatic int counterWidth(input int multCycles, input int divCycles);
    int maxCycles;
    int w;
    maxCycles = (multCycles > divCycles) ? multCycles : divCycles;
    w = $clog2(maxCycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module muldiv_cycle_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic             isZero
);

  logic [WIDTH-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared multiply/divide unit: start pulse, fixed-latency
// wait, then HI/LO commit. Zero divisors are rejected before the divider starts.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a request
// S_START | one-cycle start pulse to the selected unit, counter loaded
// S_RUN   | waiting out the unit latency (exactly N cycles)
// S_WRITE | HI/LO write enables and done; commit point, abort ignored
// S_ZERO  | DIV with zero divisor rejected, div_zero pulsed
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] op_b,
  input  logic        abort,
  output logic        req_ready,
  output logic        busy,
  output logic        mult_start,
  output logic        div_start,
  output logic        hilo_sel,
  output logic        hi_we,
  output logic        lo_we,
  output logic        done,
  output logic        div_zero
);

  localparam int CNT_W = counterWidth(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  seqState_t state;
  seqState_t nextState;
  logic      opQ;
  logic      nextOp;
  logic      cntZero;
  logic      cntLoad;
  logic      cntDec;

  // Counter is loaded while START is showing and counts down through RUN.
  assign cntLoad = (state == S_START);
  assign cntDec  = (state == S_RUN);

  muldiv_cycle_counter #(
    .WIDTH(CNT_W)
  ) uCounter (
    .clk      (clk),
    .reset    (reset),
    .load     (cntLoad),
    .loadValue(opQ ? DIV_LOAD : MULT_LOAD),
    .dec      (cntDec),
    .isZero   (cntZero)
  );

  // Next-state and latched-op selection.
  always_comb begin
    nextState = state;
    nextOp    = opQ;
    case (state)
      S_IDLE: begin
        if (req_valid && !abort) begin
          nextOp    = req_op;
          nextState = ((req_op == OP_DIV) && (op_b == 32'd0)) ? S_ZERO : S_START;
        end
      end
      S_START: nextState = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          nextState = S_IDLE;
        end else if (cntZero) begin
          nextState = S_WRITE;
        end
      end
      S_WRITE: nextState = S_IDLE;
      S_ZERO:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // State register with Moore outputs decoded from the next state so they
  // appear registered, aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      opQ        <= OP_MULT;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hilo_sel   <= 1'b0;
      hi_we      <= 1'b0;
      lo_we      <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      state      <= nextState;
      opQ        <= nextOp;
      req_ready  <= (nextState == S_IDLE);
      busy       <= (nextState != S_IDLE);
      mult_start <= (nextState == S_START) && (nextOp == OP_MULT);
      div_start  <= (nextState == S_START) && (nextOp == OP_DIV);
      hilo_sel   <= (nextState inside {S_START, S_RUN, S_WRITE}) ? nextOp : 1'b0;
      hi_we      <= (nextState == S_WRITE);
      lo_we      <= (nextState == S_WRITE);
      done       <= (nextState == S_WRITE);
      div_zero   <= (nextState == S_ZERO);
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: MULT latency 32, DIV latency 4.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_op;
  logic [31:0] op_b;
  logic        abort;
  logic        req_ready, busy, mult_start, div_start, hilo_sel;
  logic        hi_we, lo_we, done, div_zero;

  int nChecks = 0;
  int nPass   = 0;

  logic [8:0] outVec;
  assign outVec = {req_ready, busy, mult_start, div_start, hilo_sel,
                   hi_we, lo_we, done, div_zero};

  muldiv_sequencer #(
    .MULT_CYCLES(32),
    .DIV_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .op_b      (op_b),
    .abort     (abort),
    .req_ready (req_ready),
    .busy      (busy),
    .mult_start(mult_start),
    .div_start (div_start),
    .hilo_sel  (hilo_sel),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Expected outputs for a given state, written straight from the output table.
  function automatic logic [8:0] expOut(input seqState_t s, input logic op);
    logic rdy, ms, ds, hs, wr, dz;
    rdy = (s == S_IDLE);
    ms  = (s == S_START) && !op;
    ds  = (s == S_START) && op;
    hs  = ((s == S_START) || (s == S_RUN) || (s == S_WRITE)) ? op : 1'b0;
    wr  = (s == S_WRITE);
    dz  = (s == S_ZERO);
    return {rdy, !rdy, ms, ds, hs, wr, wr, wr, dz};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0b expected %0b", tag, got, exp);
  endtask

  task automatic checkOut(input string tag, input seqState_t s, input logic op);
    checkVal(tag, {23'd0, outVec}, {23'd0, expOut(s, op)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check n consecutive cycles of the same expected state, advancing each time.
  task automatic expectCycles(input string tag, input seqState_t s, input logic op, input int n);
    for (int i = 0; i < n; i++) begin
      checkOut($sformatf("%s[%0d]", tag, i), s, op);
      tick();
    end
  endtask

  // Present a request for one edge (the accepting edge 0), then drop it.
  task automatic issue(input logic op, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    op_b      = b;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; op_b = 32'd0; abort = 1'b0;
    tick(); tick();
    checkOut("reset", S_IDLE, OP_MULT);
    reset = 1'b1;
    tick();
    checkOut("postReset", S_IDLE, OP_MULT);

    // MULT, 32 cycles: START c1, RUN c2..33, WRITE c34, ready c35.
    issue(OP_MULT, 32'd7);
    expectCycles("mulStart", S_START, OP_MULT, 1);
    expectCycles("mulRun",   S_RUN,   OP_MULT, 32);
    expectCycles("mulWrite", S_WRITE, OP_MULT, 1);
    expectCycles("mulIdle",  S_IDLE,  OP_MULT, 1);

    // DIV, 4 cycles: div_start c1, hilo_sel c1..6, done c6.
    issue(OP_DIV, 32'd3);
    expectCycles("divStart", S_START, OP_DIV, 1);
    expectCycles("divRun",   S_RUN,   OP_DIV, 4);
    expectCycles("divWrite", S_WRITE, OP_DIV, 1);
    expectCycles("divIdle",  S_IDLE,  OP_DIV, 1);

    // Zero divisor: div_zero c1 only, ready c2.
    issue(OP_DIV, 32'd0);
    expectCycles("zeroPulse", S_ZERO, OP_DIV, 1);
    expectCycles("zeroIdle",  S_IDLE, OP_DIV, 2);

    // MULT with op_b == 0 is a normal MULT; abort in START drops it.
    issue(OP_MULT, 32'd0);
    checkOut("mulB0Start", S_START, OP_MULT);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expectCycles("abortStart", S_IDLE, OP_MULT, 2);

    // Abort in ZERO: still a single div_zero, then idle.
    issue(OP_DIV, 32'd0);
    checkOut("zeroAbort", S_ZERO, OP_DIV);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expectCycles("zeroAbortIdle", S_IDLE, OP_DIV, 1);

    // Abort mid-RUN at edge 10, new DIV accepted at edge 11.
    issue(OP_MULT, 32'd11);
    expectCycles("abStart", S_START, OP_MULT, 1);
    expectCycles("abRun",   S_RUN,   OP_MULT, 8);
    checkOut("abRunC10", S_RUN, OP_MULT);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOut("abIdleC11", S_IDLE, OP_MULT);
    issue(OP_DIV, 32'd5);
    expectCycles("abDivStart", S_START, OP_DIV, 1);
    expectCycles("abDivRun",   S_RUN,   OP_DIV, 4);
    expectCycles("abDivWrite", S_WRITE, OP_DIV, 1);
    expectCycles("abDivIdle",  S_IDLE,  OP_DIV, 1);

    // Abort in WRITE is ignored; then valid+abort in IDLE is not accepted.
    issue(OP_DIV, 32'd9);
    expectCycles("wrStart", S_START, OP_DIV, 1);
    expectCycles("wrRun",   S_RUN,   OP_DIV, 4);
    abort     = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MULT;
    op_b      = 32'd2;
    checkOut("wrAbortWrite", S_WRITE, OP_DIV);
    tick();
    expectCycles("idleAbortValid", S_IDLE, OP_DIV, 3);
    abort = 1'b0;
    tick();
    req_valid = 1'b0;
    checkOut("afterAbortAccept", S_START, OP_MULT);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expectCycles("afterAbortIdle", S_IDLE, OP_MULT, 1);

    // Reset at edge 5 of a DIV: reset values in c6, no write afterwards.
    issue(OP_DIV, 32'd2);
    expectCycles("rstStart", S_START, OP_DIV, 1);
    expectCycles("rstRun",   S_RUN,   OP_DIV, 3);
    checkOut("rstRunC5", S_RUN, OP_DIV);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOut("rstC6", S_IDLE, OP_MULT);
    tick();
    expectCycles("rstAfter", S_IDLE, OP_MULT, 4);

    // Request held while busy is accepted only at the first IDLE edge.
    issue(OP_DIV, 32'd4);
    req_valid = 1'b1;
    req_op    = OP_MULT;
    op_b      = 32'd8;
    expectCycles("busyStart", S_START, OP_DIV, 1);
    expectCycles("busyRun",   S_RUN,   OP_DIV, 4);
    expectCycles("busyWrite", S_WRITE, OP_DIV, 1);
    expectCycles("busyIdle",  S_IDLE,  OP_DIV, 1);
    req_valid = 1'b0;
    expectCycles("heldStart", S_START, OP_MULT, 1);
    checkOut("heldRun", S_RUN, OP_MULT);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expectCycles("heldIdle", S_IDLE, OP_MULT, 2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer that owns the shared multiply/divide resource of the multicycle CPU. It accepts one MULT or DIV request at a time from the main control unit and pulses the matching unit's start. It counts the unit's fixed latency, then commits the result to HI/LO through the hi/lo source select and write enables. Zero divisors are caught before the divider is started and reported as a divide-by-zero exception.

## Interface
Parameters:
- MULT_CYCLES, 32, cycles the multiplier needs after its start pulse; must be ≥1
- DIV_CYCLES, 32, cycles the divider needs after its start pulse; must be ≥1

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  one clock; reset is synchronous and active-low
- req_valid  in  1  control unit requests an operation
- req_op  in  1  0 = MULT, 1 = DIV
- op_b  in  32  current B register value; checked for zero divisor
- abort  in  1  flush from exception logic; cancels in-flight op
- req_ready  out  1  sequencer idle, can accept
- busy  out  1  operation in flight (any non-IDLE state)
- mult_start  out  1  one-cycle start pulse to Mult
- div_start  out  1  one-cycle start pulse to Div
- hilo_sel  out  1  HI/LO mux select (0 = mult, 1 = div)
- hi_we  out  1  HI register load
- lo_we  out  1  LO register load
- done  out  1  one-cycle pulse: HI/LO written this cycle
- div_zero  out  1  one-cycle pulse: DIV with op_b == 0 rejected

## Operation
- States: IDLE, START, RUN, WRITE, ZERO. Moore outputs only.
- Acceptance: at a rising edge, if state = IDLE, req_valid = 1 and abort = 0, the request is accepted and req_op is latched into op_q.
- IDLE → ZERO if the op is DIV and op_b == 0. Otherwise IDLE → START.
- START: mult_start = !op_q, div_start = op_q. Counter loads (op_q ? DIV_CYCLES : MULT_CYCLES) − 1. Next state is RUN.
- RUN: counter decrements each cycle. When counter = 0, next state is WRITE. RUN therefore lasts exactly N cycles.
- WRITE: hi_we = lo_we = done = 1. Next state is IDLE. WRITE is the commit point; abort is ignored in WRITE.
- ZERO: div_zero = 1. No start pulse and no HI/LO write are issued. Next state is IDLE.
- hilo_sel = op_q in START, RUN and WRITE; 0 otherwise.
- req_ready = 1 only in IDLE. busy = !req_ready.
- abort = 1 at an edge in START, RUN or ZERO forces IDLE next cycle. No write and no done follow. A div_zero already being driven completes its cycle.
- Abort in IDLE is ignored, except that it blocks acceptance.
- Requests arriving while busy are not queued. The control unit must hold req_valid until req_ready.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)) bits, unsigned, with no wrap. It is never decremented below 0.

## Timing
- Reset: reset = 0 at an edge forces IDLE, op_q = 0, counter = 0.
- Reset is valid from any state and discards the operation in flight without any write.
- After reset: req_ready = 1; busy, mult_start, div_start, hilo_sel, hi_we, lo_we, done and div_zero = 0.
- Take the accepting edge as edge 0. Then:
  - START occupies cycle 1.
  - RUN occupies cycles 2..N+1.
  - WRITE and done occupy cycle N+2.
  - HI/LO hold the result after edge N+2.
  - A new request can be accepted at edge N+3 at the earliest.
- Zero divisor: div_zero is high in cycle 1, and req_ready returns in cycle 2.
- Start pulses are exactly one cycle wide; no other cycle asserts them.

## Structure
- Shared package muldiv_pkg holds:
  - state encoding constants: S_IDLE, S_START, S_RUN, S_WRITE, S_ZERO
  - OP_MULT = 0, OP_DIV = 1
  - default cycle counts
- The control unit and bench import muldiv_pkg as well.
- One sub-module is natural: muldiv_cycle_counter, a loadable down-counter with a zero flag, parameterised on width.
- The FSM and output decode live in muldiv_sequencer.

## Test plan
- MULT, defaults: req_valid = 1, req_op = 0, op_b = 7 at edge 0 → mult_start is high in cycle 1 only. hi_we, lo_we and done are high in cycle 34 with hilo_sel = 0. req_ready is 1 again in cycle 35.
- DIV with DIV_CYCLES = 4: op_b = 3 → div_start in cycle 1; hilo_sel = 1 in cycles 1–6; done in cycle 6; no mult_start ever.
- Zero divisor: req_op = 1, op_b = 0 → div_zero in cycle 1, with div_start, hi_we, lo_we and done staying 0. req_ready is 1 in cycle 2.
- Abort mid-RUN: MULT accepted, abort = 1 at edge 10 → IDLE from cycle 11, no hi_we or done. A new DIV is accepted at edge 11 and completes normally.
- Abort in WRITE, plus abort with req_valid in IDLE:
  - Abort in WRITE is ignored; done and the writes still occur.
  - req_valid and abort together in IDLE → not accepted, and busy stays 0.
- Reset mid-operation and busy-request: reset = 0 at edge 5 of a DIV → all outputs at reset values in cycle 6, with no write afterwards. req_valid held while busy → accepted only at the first IDLE edge.
